// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite types for the single-slave transfer controller.
// Holds transfer/response codes, master count and the controller state encoding.
package ahb_lite_pkg;

    localparam int N_MASTERS = 3;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } HTRANS_state;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ADDR  = 2'b01,
        ST_DATA  = 2'b10,
        ST_DRAIN = 2'b11
    } xfer_state_t;

    function automatic logic grant_onehot(input logic [N_MASTERS-1:0] g);
        return $countones(g) == 1;
    endfunction

    function automatic logic [1:0] grant_idx(input logic [N_MASTERS-1:0] g);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (g[i]) idx = i[1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/ahb_master_mux.sv
// Combinational selector picking one master's address/control/write-data bus by index.
// An index beyond the master count yields an idle, all-zero bus.
module ahb_master_mux
    import ahb_lite_pkg::*;
(
    input  logic        [1:0]                  sel_i,
    input  HTRANS_state [N_MASTERS-1:0]        htrans_i,
    input  logic        [N_MASTERS-1:0][31:0]  haddr_i,
    input  logic        [N_MASTERS-1:0]        hwrite_i,
    input  logic        [N_MASTERS-1:0][2:0]   hsize_i,
    input  logic        [N_MASTERS-1:0][31:0]  hwdata_i,
    output HTRANS_state                        htrans_o,
    output logic        [31:0]                 haddr_o,
    output logic                               hwrite_o,
    output logic        [2:0]                  hsize_o,
    output logic        [31:0]                 hwdata_o
);

    always_comb begin
        htrans_o = HTRANS_IDLE;
        haddr_o  = '0;
        hwrite_o = 1'b0;
        hsize_o  = '0;
        hwdata_o = '0;
        if (sel_i < 2'(N_MASTERS)) begin
            htrans_o = htrans_i[sel_i];
            haddr_o  = haddr_i[sel_i];
            hwrite_o = hwrite_i[sel_i];
            hsize_o  = hsize_i[sel_i];
            hwdata_o = hwdata_i[sel_i];
        end
    end

endmodule

// File: rtl/ahb_xfer_ctrl.sv
// Issues one single AHB-Lite transfer at a time from the granted master to one slave.
// state    | meaning
// ST_IDLE  | waiting for a one-hot grant with NONSEQ from that master
// ST_ADDR  | address phase on the slave bus, held until HREADYOUT
// ST_DATA  | data phase, write data steered from the latched master
// ST_DRAIN | transfer done, waiting for the arbiter to drop that grant
module ahb_xfer_ctrl
    import ahb_lite_pkg::*;
(
    input  logic                               HCLK,
    input  logic                               HRESET,
    input  logic        [N_MASTERS-1:0]        M_GRANT,
    input  HTRANS_state [N_MASTERS-1:0]        M_HTRANS,
    input  logic        [N_MASTERS-1:0][31:0]  M_HADDR,
    input  logic        [N_MASTERS-1:0]        M_HWRITE,
    input  logic        [N_MASTERS-1:0][2:0]   M_HSIZE,
    input  logic        [N_MASTERS-1:0][31:0]  M_HWDATA,
    input  logic                               S_HREADYOUT,
    input  logic                               S_HRESP,
    input  logic        [31:0]                 S_HRDATA,
    output logic                               S_HSEL,
    output HTRANS_state                        S_HTRANS,
    output logic        [31:0]                 S_HADDR,
    output logic                               S_HWRITE,
    output logic        [2:0]                  S_HSIZE,
    output logic        [31:0]                 S_HWDATA,
    output logic        [N_MASTERS-1:0]        slave_done,
    output logic        [31:0]                 M_HRDATA,
    output logic                               M_HRESP,
    output logic                               busy
);

    xfer_state_t                state_q;
    logic        [1:0]          idx_q;
    logic                       hsel_q;
    HTRANS_state                htrans_q;
    logic        [31:0]         haddr_q;
    logic                       hwrite_q;
    logic        [2:0]          hsize_q;
    logic        [N_MASTERS-1:0] done_q;
    logic        [31:0]         hrdata_q;
    logic                       hresp_q;
    logic                       busy_q;

    logic        [1:0]          sel_idx;
    HTRANS_state                mux_htrans;
    logic        [31:0]         mux_haddr;
    logic                       mux_hwrite;
    logic        [2:0]          mux_hsize;
    logic        [31:0]         mux_hwdata;
    logic                       accept_d;

    // In IDLE the mux looks at the candidate grant; afterwards it stays on the latched master.
    assign sel_idx  = (state_q == ST_IDLE) ? grant_idx(M_GRANT) : idx_q;
    assign accept_d = grant_onehot(M_GRANT) && (mux_htrans == HTRANS_NONSEQ);

    ahb_master_mux u_mux (
        .sel_i    (sel_idx),
        .htrans_i (M_HTRANS),
        .haddr_i  (M_HADDR),
        .hwrite_i (M_HWRITE),
        .hsize_i  (M_HSIZE),
        .hwdata_i (M_HWDATA),
        .htrans_o (mux_htrans),
        .haddr_o  (mux_haddr),
        .hwrite_o (mux_hwrite),
        .hsize_o  (mux_hsize),
        .hwdata_o (mux_hwdata)
    );

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            hsel_q   <= 1'b0;
            htrans_q <= HTRANS_IDLE;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= '0;
            done_q   <= '0;
            hrdata_q <= '0;
            hresp_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_d) begin
                        state_q  <= ST_ADDR;
                        idx_q    <= sel_idx;
                        hsel_q   <= 1'b1;
                        htrans_q <= HTRANS_NONSEQ;
                        haddr_q  <= mux_haddr;
                        hwrite_q <= mux_hwrite;
                        hsize_q  <= mux_hsize;
                        busy_q   <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (S_HREADYOUT) begin
                        state_q  <= ST_DATA;
                        hsel_q   <= 1'b0;
                        htrans_q <= HTRANS_IDLE;
                    end
                end
                ST_DATA: begin
                    if (S_HREADYOUT) begin
                        state_q <= ST_DRAIN;
                        if (!hwrite_q) hrdata_q <= S_HRDATA;
                        hresp_q <= S_HRESP;
                        done_q  <= N_MASTERS'(1) << idx_q;
                    end
                end
                ST_DRAIN: begin
                    // Wait out the arbiter's grant release so the same request is not reissued.
                    if (!M_GRANT[idx_q]) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    hsel_q   <= 1'b0;
                    htrans_q <= HTRANS_IDLE;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign S_HSEL     = hsel_q;
    assign S_HTRANS   = htrans_q;
    assign S_HADDR    = haddr_q;
    assign S_HWRITE   = hwrite_q;
    assign S_HSIZE    = hsize_q;
    assign S_HWDATA   = mux_hwdata;
    assign slave_done = done_q;
    assign M_HRDATA   = hrdata_q;
    assign M_HRESP    = hresp_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ahb_xfer_ctrl.sv
// Directed bench for ahb_xfer_ctrl: read/write flows, wait states, grant edge cases, reset.
module tb_ahb_xfer_ctrl;
    import ahb_lite_pkg::*;

    logic                              HCLK;
    logic                              HRESET;
    logic        [2:0]                 M_GRANT;
    HTRANS_state [2:0]                 M_HTRANS;
    logic        [2:0][31:0]           M_HADDR;
    logic        [2:0]                 M_HWRITE;
    logic        [2:0][2:0]            M_HSIZE;
    logic        [2:0][31:0]           M_HWDATA;
    logic                              S_HREADYOUT;
    logic                              S_HRESP;
    logic        [31:0]                S_HRDATA;
    logic                              S_HSEL;
    HTRANS_state                       S_HTRANS;
    logic        [31:0]                S_HADDR;
    logic                              S_HWRITE;
    logic        [2:0]                 S_HSIZE;
    logic        [31:0]                S_HWDATA;
    logic        [2:0]                 slave_done;
    logic        [31:0]                M_HRDATA;
    logic                              M_HRESP;
    logic                              busy;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt;
    int sel_cnt;

    ahb_xfer_ctrl dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .M_GRANT     (M_GRANT),
        .M_HTRANS    (M_HTRANS),
        .M_HADDR     (M_HADDR),
        .M_HWRITE    (M_HWRITE),
        .M_HSIZE     (M_HSIZE),
        .M_HWDATA    (M_HWDATA),
        .S_HREADYOUT (S_HREADYOUT),
        .S_HRESP     (S_HRESP),
        .S_HRDATA    (S_HRDATA),
        .S_HSEL      (S_HSEL),
        .S_HTRANS    (S_HTRANS),
        .S_HADDR     (S_HADDR),
        .S_HWRITE    (S_HWRITE),
        .S_HSIZE     (S_HSIZE),
        .S_HWDATA    (S_HWDATA),
        .slave_done  (slave_done),
        .M_HRDATA    (M_HRDATA),
        .M_HRESP     (M_HRESP),
        .busy        (busy)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_inputs();
        M_GRANT     = '0;
        M_HTRANS    = {HTRANS_IDLE, HTRANS_IDLE, HTRANS_IDLE};
        M_HADDR     = '0;
        M_HWRITE    = '0;
        M_HSIZE     = '0;
        M_HWDATA    = '0;
        S_HREADYOUT = 1'b1;
        S_HRESP     = 1'b0;
        S_HRDATA    = '0;
    endtask

    initial begin
        idle_inputs();
        HRESET = 1'b1;
        tick();
        tick();
        chk("rst_hsel", 32'(S_HSEL), 32'd0);
        chk("rst_htrans", 32'(S_HTRANS), 32'd0);
        chk("rst_haddr", S_HADDR, 32'd0);
        chk("rst_done", 32'(slave_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hrdata", M_HRDATA, 32'd0);
        HRESET = 1'b0;
        tick();

        // CPU zero-wait read, grant held two cycles past done with NONSEQ still up
        M_GRANT     = 3'b001;
        M_HTRANS[0] = HTRANS_NONSEQ;
        M_HADDR[0]  = 32'h0000_1000;
        M_HWRITE[0] = 1'b0;
        M_HSIZE[0]  = 3'd2;
        S_HRDATA    = 32'hDEAD_BEEF;
        tick();
        chk("rd_c1_hsel", 32'(S_HSEL), 32'd1);
        chk("rd_c1_htrans", 32'(S_HTRANS), 32'(HTRANS_NONSEQ));
        chk("rd_c1_haddr", S_HADDR, 32'h0000_1000);
        chk("rd_c1_hsize", 32'(S_HSIZE), 32'd2);
        chk("rd_c1_hwrite", 32'(S_HWRITE), 32'd0);
        chk("rd_c1_busy", 32'(busy), 32'd1);
        tick();
        chk("rd_c2_hsel", 32'(S_HSEL), 32'd0);
        chk("rd_c2_htrans", 32'(S_HTRANS), 32'(HTRANS_IDLE));
        chk("rd_c2_done", 32'(slave_done), 32'd0);
        tick();
        chk("rd_c3_done", 32'(slave_done), 32'b001);
        chk("rd_c3_hrdata", M_HRDATA, 32'hDEAD_BEEF);
        chk("rd_c3_hresp", 32'(M_HRESP), 32'd0);
        done_cnt = 0;
        sel_cnt  = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (slave_done != 3'b000) done_cnt++;
            if (S_HSEL) sel_cnt++;
            chk("drain_busy", 32'(busy), 32'd1);
        end
        chk("drain_no_done", 32'(done_cnt), 32'd0);
        chk("drain_no_reissue", 32'(sel_cnt), 32'd0);
        M_GRANT     = 3'b000;
        M_HTRANS[0] = HTRANS_IDLE;
        tick();
        chk("drain_exit_busy", 32'(busy), 32'd0);
        tick();

        // Other master write with two data-phase wait states, grant lost mid-transfer
        M_GRANT     = 3'b100;
        M_HTRANS[2] = HTRANS_NONSEQ;
        M_HADDR[2]  = 32'h0000_2004;
        M_HWRITE[2] = 1'b1;
        M_HSIZE[2]  = 3'd1;
        M_HWDATA[2] = 32'h0000_55AA;
        S_HRDATA    = 32'h1234_5678;
        tick();
        chk("wr_c1_hsel", 32'(S_HSEL), 32'd1);
        chk("wr_c1_haddr", S_HADDR, 32'h0000_2004);
        chk("wr_c1_hwrite", 32'(S_HWRITE), 32'd1);
        M_HTRANS[2] = HTRANS_IDLE;
        tick();
        chk("wr_c2_hwdata", S_HWDATA, 32'h0000_55AA);
        S_HREADYOUT = 1'b0;
        tick();
        chk("wr_c3_hwdata", S_HWDATA, 32'h0000_55AA);
        chk("wr_c3_done", 32'(slave_done), 32'd0);
        M_GRANT = 3'b000;
        tick();
        chk("wr_c4_hwdata", S_HWDATA, 32'h0000_55AA);
        chk("wr_c4_done", 32'(slave_done), 32'd0);
        chk("wr_c4_busy", 32'(busy), 32'd1);
        S_HREADYOUT = 1'b1;
        tick();
        chk("wr_c5_done", 32'(slave_done), 32'b100);
        chk("wr_c5_hrdata_kept", M_HRDATA, 32'hDEAD_BEEF);
        tick();
        chk("wr_c6_done_clr", 32'(slave_done), 32'd0);
        chk("wr_c6_busy", 32'(busy), 32'd0);

        // Multi-hot, zero grant and BUSY/SEQ requests are all refused
        M_GRANT     = 3'b011;
        M_HTRANS[0] = HTRANS_NONSEQ;
        M_HTRANS[1] = HTRANS_NONSEQ;
        sel_cnt     = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (S_HSEL || busy) sel_cnt++;
        end
        chk("multihot_ignored", 32'(sel_cnt), 32'd0);
        M_GRANT = 3'b000;
        tick();
        tick();
        chk("nogrant_busy", 32'(busy), 32'd0);
        M_HTRANS[0] = HTRANS_IDLE;
        M_GRANT     = 3'b010;
        M_HTRANS[1] = HTRANS_SEQ;
        tick();
        M_HTRANS[1] = HTRANS_BUSY;
        tick();
        chk("seq_busy_ignored", 32'(busy), 32'd0);
        chk("seq_busy_hsel", 32'(S_HSEL), 32'd0);

        // CoreSystem read completing with ERROR
        M_HTRANS[1] = HTRANS_NONSEQ;
        M_HADDR[1]  = 32'h0000_3008;
        M_HWRITE[1] = 1'b0;
        S_HRDATA    = 32'hCAFE_F00D;
        S_HRESP     = 1'b1;
        tick();
        chk("err_c1_haddr", S_HADDR, 32'h0000_3008);
        M_HTRANS[1] = HTRANS_IDLE;
        tick();
        tick();
        chk("err_c3_done", 32'(slave_done), 32'b010);
        chk("err_c3_hresp", 32'(M_HRESP), 32'd1);
        chk("err_c3_hrdata", M_HRDATA, 32'hCAFE_F00D);
        M_GRANT = 3'b000;
        S_HRESP = 1'b0;
        tick();
        tick();

        // Asynchronous reset while stalled in the data phase
        M_GRANT     = 3'b001;
        M_HTRANS[0] = HTRANS_NONSEQ;
        M_HADDR[0]  = 32'h0000_4000;
        tick();
        M_HTRANS[0] = HTRANS_IDLE;
        M_GRANT     = 3'b000;
        tick();
        S_HREADYOUT = 1'b0;
        chk("rst_pre_busy", 32'(busy), 32'd1);
        #2;
        HRESET = 1'b1;
        #1;
        chk("async_rst_hsel", 32'(S_HSEL), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_haddr", S_HADDR, 32'd0);
        chk("async_rst_hrdata", M_HRDATA, 32'd0);
        tick();
        HRESET      = 1'b0;
        S_HREADYOUT = 1'b1;
        done_cnt    = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (slave_done != 3'b000) done_cnt++;
        end
        chk("rst_no_done", 32'(done_cnt), 32'd0);
        chk("rst_stays_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
